// File: rtl/spi_master_byte.sv
// Byte-oriented SPI master, mode 0 (CPOL=0, CPHA=0), MSB first.
// Chip select stays asserted across a multi-byte stream until a byte
// flagged tx_last has been shifted out, then is released after CS_HOLD cycles.
//
// Ports:
//   clk       system clock
//   reset     synchronous, active-high reset
//   tx_byte   byte to send, sampled when tx_valid && tx_ready
//   tx_valid  upstream has a byte
//   tx_last   sampled with tx_byte; release cs after this byte
//   tx_ready  block accepts a byte this cycle
//   rx_byte   byte shifted in from miso, valid with rx_valid
//   rx_valid  one-cycle pulse per completed byte
//   busy      high whenever the engine is not idle
//   sck       SPI clock, idle low
//   cs        chip select, active low
//   mosi      serial data out
//   miso      serial data in (already synchronous to clk)
module spi_master_byte #(
    parameter int unsigned CLK_DIV  = 8,
    parameter int unsigned CS_SETUP = 4,
    parameter int unsigned CS_HOLD  = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_byte,
    input  logic       tx_valid,
    input  logic       tx_last,
    output logic       tx_ready,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic       busy,
    output logic       sck,
    output logic       cs,
    output logic       mosi,
    input  logic       miso
);

    localparam int unsigned MAX_A   = (CLK_DIV > CS_SETUP) ? CLK_DIV : CS_SETUP;
    localparam int unsigned MAX_CNT = (MAX_A > CS_HOLD) ? MAX_A : CS_HOLD;
    localparam int unsigned CNT_W   = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;

    localparam logic [CNT_W-1:0] DIV_END   = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] SETUP_END = CNT_W'(CS_SETUP - 1);
    localparam logic [CNT_W-1:0] HOLD_END  = CNT_W'(CS_HOLD - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        LOW   = 3'd2,
        HIGH  = 3'd3,
        NEXT  = 3'd4,
        HOLD  = 3'd5
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_cnt;
    logic [7:0]       tx_sh;
    logic [7:0]       rx_sh;
    logic             last_q;

    // Single-process FSM; every output is a register updated here.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            bit_cnt  <= '0;
            tx_sh    <= '0;
            rx_sh    <= '0;
            last_q   <= 1'b0;
            tx_ready <= 1'b1;
            rx_byte  <= '0;
            rx_valid <= 1'b0;
            busy     <= 1'b0;
            sck      <= 1'b0;
            cs       <= 1'b1;
            mosi     <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (tx_valid && tx_ready) begin
                        tx_sh    <= tx_byte;
                        last_q   <= tx_last;
                        mosi     <= tx_byte[7];
                        cs       <= 1'b0;
                        busy     <= 1'b1;
                        tx_ready <= 1'b0;
                        cnt      <= '0;
                        bit_cnt  <= '0;
                        state    <= SETUP;
                    end
                end

                SETUP: begin
                    if (cnt == SETUP_END) begin
                        cnt   <= '0;
                        state <= LOW;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                // Slave has had the full low phase to present its bit; sample on the rise.
                LOW: begin
                    if (cnt == DIV_END) begin
                        cnt   <= '0;
                        sck   <= 1'b1;
                        rx_sh <= {rx_sh[6:0], miso};
                        state <= HIGH;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                HIGH: begin
                    if (cnt == DIV_END) begin
                        cnt <= '0;
                        sck <= 1'b0;
                        if (bit_cnt == 3'd7) begin
                            rx_byte  <= rx_sh;
                            rx_valid <= 1'b1;
                            if (last_q) begin
                                state <= HOLD;
                            end else begin
                                tx_ready <= 1'b1;
                                state    <= NEXT;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                            tx_sh   <= {tx_sh[6:0], 1'b0};
                            mosi    <= tx_sh[6];
                            state   <= LOW;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                // Mid-stream: cs held low, skip the setup delay on the next byte.
                NEXT: begin
                    if (tx_valid && tx_ready) begin
                        tx_sh    <= tx_byte;
                        last_q   <= tx_last;
                        mosi     <= tx_byte[7];
                        tx_ready <= 1'b0;
                        cnt      <= '0;
                        bit_cnt  <= '0;
                        state    <= LOW;
                    end
                end

                // tx_ready rises together with cs so cs is high for at least one cycle.
                HOLD: begin
                    if (cnt == HOLD_END) begin
                        cnt      <= '0;
                        cs       <= 1'b1;
                        mosi     <= 1'b0;
                        busy     <= 1'b0;
                        tx_ready <= 1'b1;
                        state    <= IDLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                default: begin
                    state    <= IDLE;
                    cnt      <= '0;
                    sck      <= 1'b0;
                    cs       <= 1'b1;
                    mosi     <= 1'b0;
                    busy     <= 1'b0;
                    tx_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master_byte.sv
// Self-checking bench for spi_master_byte: random bytes and miso patterns
// checked against a bit-level model of the SPI wire protocol.
module tb_spi_master_byte;

    localparam int unsigned CLK_DIV  = 2;
    localparam int unsigned CS_SETUP = 3;
    localparam int unsigned CS_HOLD  = 3;
    localparam int          BUDGET   = 400;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] tx_byte;
    logic       tx_valid;
    logic       tx_last;
    logic       tx_ready;
    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       busy;
    logic       sck;
    logic       cs;
    logic       mosi;
    logic       miso;

    // 0: loopback, 1: random per bit, 2: constant miso_r
    int   miso_mode = 0;
    logic miso_r    = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    // Wire-level observations
    bit mosi_q[$];
    bit miso_q[$];
    int rises    = 0;
    int cs_rises = 0;
    int cs_bad   = 0;
    int n_rx     = 0;

    spi_master_byte #(
        .CLK_DIV (CLK_DIV),
        .CS_SETUP(CS_SETUP),
        .CS_HOLD (CS_HOLD)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .tx_byte (tx_byte),
        .tx_valid(tx_valid),
        .tx_last (tx_last),
        .tx_ready(tx_ready),
        .rx_byte (rx_byte),
        .rx_valid(rx_valid),
        .busy    (busy),
        .sck     (sck),
        .cs      (cs),
        .mosi    (mosi),
        .miso    (miso)
    );

    always #5 clk = ~clk;

    assign miso = (miso_mode == 0) ? mosi : miso_r;

    // Slave-side behaviour: present a new bit after each falling sck / cs assertion.
    always @(negedge cs or negedge sck) begin
        if (miso_mode == 1) miso_r = 1'($urandom);
    end

    always @(posedge sck) begin
        mosi_q.push_back(mosi);
        miso_q.push_back(miso);
        rises++;
        if (cs !== 1'b0) cs_bad++;
    end

    always @(posedge cs) cs_rises++;

    always @(negedge clk) if (rx_valid === 1'b1) n_rx++;

    // Byte k on the wire, MSB first, as seen at the sck rising edges.
    function automatic logic [7:0] mosi_byte(input int k);
        logic [7:0] v = '0;
        for (int i = 0; i < 8; i++)
            if (8*k + i < mosi_q.size()) v = {v[6:0], 1'(mosi_q[8*k+i])};
        return v;
    endfunction

    function automatic logic [7:0] miso_byte(input int k);
        logic [7:0] v = '0;
        for (int i = 0; i < 8; i++)
            if (8*k + i < miso_q.size()) v = {v[6:0], 1'(miso_q[8*k+i])};
        return v;
    endfunction

    task automatic clear_obs();
        mosi_q.delete();
        miso_q.delete();
        rises    = 0;
        cs_rises = 0;
        cs_bad   = 0;
        n_rx     = 0;
    endtask

    // Present one byte at a negedge; it is taken at the next posedge if tx_ready.
    task automatic send(input logic [7:0] b, input logic last);
        int t = 0;
        while (tx_ready !== 1'b1 && t < BUDGET) begin
            @(negedge clk);
            t++;
        end
        n_checks++;
        if (t >= BUDGET) begin
            n_errors++;
            $display("FAIL send_ready_timeout: tx_ready=%b required 1", tx_ready);
        end
        tx_byte  = b;
        tx_last  = last;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    // Returns at the negedge where rx_valid is seen.
    task automatic wait_rx(output logic [7:0] got);
        int t = 0;
        got = 'x;
        while (t < BUDGET) begin
            if (rx_valid === 1'b1) break;
            @(negedge clk);
            t++;
        end
        n_checks++;
        if (t >= BUDGET) begin
            n_errors++;
            $display("FAIL rx_valid_timeout: rx_valid=%b required 1", rx_valid);
        end else begin
            got = rx_byte;
        end
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        tx_valid = 1'b0;
        tx_byte  = '0;
        tx_last  = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if ({tx_ready, rx_valid, rx_byte, busy, sck, cs, mosi} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0}) begin
            n_errors++;
            $display("FAIL reset_values: rdy=%b rxv=%b rx=%h busy=%b sck=%b cs=%b mosi=%b required 1 0 00 0 0 1 0",
                     tx_ready, rx_valid, rx_byte, busy, sck, cs, mosi);
        end
    endtask

    task automatic test_single();
        logic [7:0] got;
        int k;
        clear_obs();
        miso_mode = 0;
        send(8'hA5, 1'b1);
        wait_rx(got);
        n_checks++;
        if (rises !== 8) begin
            n_errors++;
            $display("FAIL single_rises: %0d required 8", rises);
        end
        n_checks++;
        if (mosi_byte(0) !== 8'hA5) begin
            n_errors++;
            $display("FAIL single_mosi: %h required a5", mosi_byte(0));
        end
        n_checks++;
        if (got !== 8'hA5) begin
            n_errors++;
            $display("FAIL single_rx: %h required a5", got);
        end
        // cs must stay low CS_HOLD cycles after the final sck fall
        k = 0;
        while (cs !== 1'b1 && k < BUDGET) begin
            @(negedge clk);
            k++;
        end
        n_checks++;
        if (k != CS_HOLD) begin
            n_errors++;
            $display("FAIL single_cs_hold: %0d cycles required %0d", k, CS_HOLD);
        end
        n_checks++;
        if (busy !== 1'b0 || tx_ready !== 1'b1 || sck !== 1'b0) begin
            n_errors++;
            $display("FAIL single_idle: busy=%b rdy=%b sck=%b required 0 1 0", busy, tx_ready, sck);
        end
    endtask

    // Stream of bytes; the last one releases cs. miso random per bit.
    task automatic run_stream(input logic [7:0] bytes[$], input string name);
        logic [7:0] got;
        int n = bytes.size();
        clear_obs();
        miso_mode = 1;
        for (int i = 0; i < n; i++) begin
            send(bytes[i], 1'(i == n - 1));
            wait_rx(got);
            n_checks++;
            if (got !== miso_byte(i) || mosi_byte(i) !== bytes[i]) begin
                n_errors++;
                $display("FAIL %s_byte%0d: rx=%h mosi=%h required rx=%h mosi=%h",
                         name, i, got, mosi_byte(i), miso_byte(i), bytes[i]);
            end
        end
        repeat (CS_HOLD + 2) @(negedge clk);
        n_checks++;
        if (rises !== 8 * n || cs_bad !== 0 || cs_rises !== 1 || n_rx !== n) begin
            n_errors++;
            $display("FAIL %s_framing: rises=%0d cs_bad=%0d cs_rises=%0d rx=%0d required %0d 0 1 %0d",
                     name, rises, cs_bad, cs_rises, n_rx, 8 * n, n);
        end
    endtask

    task automatic test_stream();
        logic [7:0] b[$];
        b = '{8'h01, 8'h80, 8'hFF};
        run_stream(b, "stream");
    endtask

    task automatic test_next_wait();
        logic [7:0] got;
        int bad = 0;
        clear_obs();
        miso_mode = 0;
        send(8'h96, 1'b0);
        wait_rx(got);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (cs !== 1'b0 || sck !== 1'b0 || tx_ready !== 1'b1 || busy !== 1'b1) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_errors++;
            $display("FAIL next_wait_idle: %0d bad cycles required 0", bad);
        end
        send(8'h3C, 1'b1);
        wait_rx(got);
        n_checks++;
        if (got !== 8'h3C || mosi_byte(1) !== 8'h3C || cs_rises !== 0) begin
            n_errors++;
            $display("FAIL next_wait_byte: rx=%h mosi=%h cs_rises=%0d required 3c 3c 0", got, mosi_byte(1), cs_rises);
        end
        repeat (CS_HOLD + 2) @(negedge clk);
    endtask

    task automatic test_independence();
        logic [7:0] got;
        clear_obs();
        miso_mode = 2;
        miso_r    = 1'b1;
        send(8'h00, 1'b1);
        wait_rx(got);
        n_checks++;
        if (got !== 8'hFF || mosi_byte(0) !== 8'h00) begin
            n_errors++;
            $display("FAIL indep_ones: rx=%h mosi=%h required ff 00", got, mosi_byte(0));
        end
        repeat (CS_HOLD + 2) @(negedge clk);
        clear_obs();
        miso_r = 1'b0;
        send(8'hFF, 1'b1);
        wait_rx(got);
        n_checks++;
        if (got !== 8'h00 || mosi_byte(0) !== 8'hFF) begin
            n_errors++;
            $display("FAIL indep_zeros: rx=%h mosi=%h required 00 ff", got, mosi_byte(0));
        end
        repeat (CS_HOLD + 2) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        logic [7:0] got;
        int t = 0;
        clear_obs();
        miso_mode = 0;
        send(8'hC3, 1'b1);
        while (rises < 3 && t < BUDGET) begin
            @(negedge clk);
            t++;
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_checks++;
        if (cs !== 1'b1 || sck !== 1'b0 || busy !== 1'b0 || mosi !== 1'b0 || tx_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL midreset_state: cs=%b sck=%b busy=%b mosi=%b rdy=%b required 1 0 0 0 1",
                     cs, sck, busy, mosi, tx_ready);
        end
        repeat (40) @(negedge clk);
        n_checks++;
        if (n_rx !== 0 || rises !== 3) begin
            n_errors++;
            $display("FAIL midreset_quiet: rx=%0d rises=%0d required 0 3", n_rx, rises);
        end
        clear_obs();
        send(8'h5A, 1'b1);
        wait_rx(got);
        n_checks++;
        if (got !== 8'h5A || mosi_byte(0) !== 8'h5A || rises !== 8) begin
            n_errors++;
            $display("FAIL midreset_after: rx=%h mosi=%h rises=%0d required 5a 5a 8", got, mosi_byte(0), rises);
        end
        repeat (CS_HOLD + 2) @(negedge clk);
    endtask

    task automatic test_random();
        logic [7:0] b[$];
        for (int r = 0; r < 4; r++) begin
            b.delete();
            for (int i = 0; i < 1 + int'($urandom_range(3)); i++) b.push_back(8'($urandom));
            run_stream(b, "random");
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_stream();
        test_next_wait();
        test_independence();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
